// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants one of write burst, read burst or auto-refresh to the
// SDRAM command engine, and keeps track of refreshes owed.
//
// Parameters:
//   REF_INTERVAL  clocks between refresh ticks (timer counts 0..REF_INTERVAL-1)
//   REF_PEND_MAX  maximum refreshes held pending (1..15)
//
// Ports:
//   i_clk           sole clock, rising edge
//   i_rst_n         synchronous active-low reset
//   i_init_done     SDRAM power-up init complete (level); low forces idle
//   i_wr_req        write-burst request (level)
//   i_rd_req        read-burst request (level)
//   i_done          one-cycle pulse: granted operation finished
//   o_wr_gnt        write burst granted (registered)
//   o_rd_gnt        read burst granted (registered)
//   o_ref_gnt       auto-refresh granted (registered)
//   o_busy          state is not idle
//   o_ref_pending   refreshes owed
//   o_ref_overflow  sticky: a refresh tick was lost at saturation
//
// Configuration macro SDRAM_ARB_REFRESH_POSTPONE_EN: when defined, pending
// refreshes yield to data requests until the pending count saturates.
// When undefined, any pending refresh is granted ahead of data requests.

module sdram_arbiter #(
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned REF_PEND_MAX = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_init_done,
    input  logic       i_wr_req,
    input  logic       i_rd_req,
    input  logic       i_done,
    output logic       o_wr_gnt,
    output logic       o_rd_gnt,
    output logic       o_ref_gnt,
    output logic       o_busy,
    output logic [3:0] o_ref_pending,
    output logic       o_ref_overflow
);

    localparam int unsigned TimerW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(REF_INTERVAL - 1);
    localparam logic [3:0] PendMax = 4'(REF_PEND_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StGntWr,
        StGntRd,
        StGntRef
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              last_wr_q, last_wr_d;   // last data grant was a write
    logic              wr_gnt_q, rd_gnt_q, ref_gnt_q;

    logic tick;
    logic ref_done;
    logic ref_want;

    // Refresh timer and pending-count bookkeeping.
    always_comb begin
        timer_d    = timer_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        tick       = 1'b0;
        ref_done   = 1'b0;

        if (!i_init_done) begin
            timer_d   = '0;
            pending_d = '0;
        end else begin
            tick     = (timer_q == TimerLast);
            timer_d  = tick ? '0 : timer_q + 1'b1;
            ref_done = (state_q == StGntRef) && i_done;

            // A tick and a refresh completion in the same cycle cancel out.
            if (tick && !ref_done) begin
                if (pending_q >= PendMax) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d = pending_q + 4'd1;
                end
            end else if (ref_done && !tick && (pending_q != '0)) begin
                pending_d = pending_q - 4'd1;
            end
        end
    end

`ifdef SDRAM_ARB_REFRESH_POSTPONE_EN
    assign ref_want = ((pending_q != '0) && !i_wr_req && !i_rd_req) ||
                      (pending_q >= PendMax);
`else
    assign ref_want = (pending_q != '0);
`endif

    // Grant FSM: decisions only in idle; grant states wait for i_done.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;

        if (!i_init_done) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ref_want) begin
                        state_d = StGntRef;
                    end else if (i_wr_req && i_rd_req) begin
                        state_d   = last_wr_q ? StGntRd : StGntWr;
                        last_wr_d = !last_wr_q;
                    end else if (i_wr_req) begin
                        state_d   = StGntWr;
                        last_wr_d = 1'b1;
                    end else if (i_rd_req) begin
                        state_d   = StGntRd;
                        last_wr_d = 1'b0;
                    end
                end
                StGntWr, StGntRd, StGntRef: begin
                    if (i_done) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            last_wr_q  <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            ref_gnt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            last_wr_q  <= last_wr_d;
            wr_gnt_q   <= (state_d == StGntWr);
            rd_gnt_q   <= (state_d == StGntRd);
            ref_gnt_q  <= (state_d == StGntRef);
        end
    end

    assign o_wr_gnt       = wr_gnt_q;
    assign o_rd_gnt       = rd_gnt_q;
    assign o_ref_gnt      = ref_gnt_q;
    assign o_busy         = (state_q != StIdle);
    assign o_ref_pending  = pending_q;
    assign o_ref_overflow = overflow_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter (REF_INTERVAL=16, REF_PEND_MAX=4) checked
// cycle by cycle against a behavioural model of the arbitration rules.

module tb_sdram_arbiter;

    localparam int RI = 16;
    localparam int PM = 4;

    logic       clk;
    logic       rst_n;
    logic       init_done;
    logic       wr_req;
    logic       rd_req;
    logic       done;
    logic       wr_gnt;
    logic       rd_gnt;
    logic       ref_gnt;
    logic       busy;
    logic [3:0] ref_pending;
    logic       ref_overflow;

    sdram_arbiter #(
        .REF_INTERVAL(RI),
        .REF_PEND_MAX(PM)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_init_done   (init_done),
        .i_wr_req      (wr_req),
        .i_rd_req      (rd_req),
        .i_done        (done),
        .o_wr_gnt      (wr_gnt),
        .o_rd_gnt      (rd_gnt),
        .o_ref_gnt     (ref_gnt),
        .o_busy        (busy),
        .o_ref_pending (ref_pending),
        .o_ref_overflow(ref_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int cyc;

    // Reference model. owner: "" idle, "WR", "RD", "REF".
    string m_owner;
    int    m_elapsed;    // clocks since init (timer position)
    int    m_owed;       // refreshes owed
    bit    m_lost;       // a tick was lost at saturation
    string m_last_data;  // last data grant, "RD" after reset

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit refresh_first(input bit w, input bit r);
`ifdef SDRAM_ARB_REFRESH_POSTPONE_EN
        return (m_owed > 0 && !w && !r) || (m_owed == PM);
`else
        return (m_owed > 0);
`endif
    endfunction

    task automatic model_edge(input bit rs, input bit in, input bit w, input bit r, input bit d);
        bit tick;
        bit served;
        if (!rs) begin
            m_owner = ""; m_elapsed = 0; m_owed = 0; m_lost = 0; m_last_data = "RD";
            return;
        end
        if (!in) begin
            m_owner = ""; m_elapsed = 0; m_owed = 0;
            return;
        end
        tick      = ((m_elapsed % RI) == RI - 1);
        m_elapsed = (m_elapsed + 1) % RI;
        served    = (m_owner == "REF") && d;
        // Decision uses the owed count from before this edge.
        if (m_owner == "") begin
            if (refresh_first(w, r)) m_owner = "REF";
            else if (w && r) m_owner = (m_last_data == "WR") ? "RD" : "WR";
            else if (w) m_owner = "WR";
            else if (r) m_owner = "RD";
            if (m_owner == "WR" || m_owner == "RD") m_last_data = m_owner;
        end else if (d) begin
            m_owner = "";
        end
        m_owed = m_owed + int'(tick) - int'(served);
        if (m_owed > PM) begin
            m_owed = PM;
            m_lost = 1;
        end
    endtask

    task automatic step(input bit rs, input bit in, input bit w, input bit r, input bit d);
        @(negedge clk);
        rst_n = rs; init_done = in; wr_req = w; rd_req = r; done = d;
        @(posedge clk);
        model_edge(rs, in, w, r, d);
        cyc++;
        #1;
        check("wr_gnt",   int'(wr_gnt),       int'(m_owner == "WR"));
        check("rd_gnt",   int'(rd_gnt),       int'(m_owner == "RD"));
        check("ref_gnt",  int'(ref_gnt),      int'(m_owner == "REF"));
        check("busy",     int'(busy),         int'(m_owner != ""));
        check("pending",  int'(ref_pending),  m_owed);
        check("overflow", int'(ref_overflow), int'(m_lost));
    endtask

    // Phase table: request, done, init-drop and reset probabilities in percent.
    int p_wr   [6] = '{50, 90, 20,  0, 60, 100};
    int p_rd   [6] = '{50, 90, 20,  0, 60,   0};
    int p_done [6] = '{30, 25,  3, 50, 20,   2};
    int p_init [6] = '{ 0,  0,  0,  0,  3,   0};
    int p_rst  [6] = '{ 0,  0,  0,  0,  1,   0};

    function automatic bit chance(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        m_owner = ""; m_elapsed = 0; m_owed = 0; m_lost = 0; m_last_data = "RD";
        rst_n = 1'b0; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0; done = 1'b0;

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single write, then idle long enough for a refresh tick.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Both requests held, done three cycles into each grant.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        end

        // Reset during a write grant, init drop during a read grant.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 1500; k++) begin
                step(!chance(p_rst[p]), !chance(p_init[p]), chance(p_wr[p]),
                     chance(p_rd[p]), chance(p_done[p]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REF_INTERVAL, default 780, clocks between auto-refresh ticks (7.8 us at 100 MHz).
REQ-002 Parameter REF_PEND_MAX, default 8, maximum refreshes held pending (range 1..15).
REQ-003 Clocking and reset are fixed: one clock; reset is synchronous and active-low.
REQ-004 i_clk  input  1  sole clock, all logic on rising edge.
REQ-005 i_rst_n  input  1  synchronous active-low reset.
REQ-006 i_init_done  input  1  SDRAM power-up init sequence complete, level.
REQ-007 i_wr_req  input  1  write-burst requester (input FIFO has a burst ready), level.
REQ-008 i_rd_req  input  1  read-burst requester, level.
REQ-009 i_done  input  1  one-cycle pulse from command engine: granted operation finished.
REQ-010 o_wr_gnt  output  1  write burst granted, registered.
REQ-011 o_rd_gnt  output  1  read burst granted, registered.
REQ-012 o_ref_gnt  output  1  auto-refresh granted, registered.
REQ-013 o_busy  output  1  high whenever the state is not IDLE.
REQ-014 o_ref_pending  output  4  count of refreshes owed, unsigned.
REQ-015 o_ref_overflow  output  1  sticky: a refresh tick was lost at saturation.

Function
REQ-016 States IDLE, GNT_WR, GNT_RD, GNT_REF; grants are one-hot: at most one of o_wr_gnt/o_rd_gnt/o_ref_gnt high, equal to the matching state.
REQ-017 Refresh timer counts 0..REF_INTERVAL-1 while i_init_done=1, wraps to 0, produces a tick on the wrap cycle.
REQ-018 Tick increments o_ref_pending; at REF_PEND_MAX a tick leaves it unchanged and sets o_ref_overflow.
REQ-019 i_done in GNT_REF decrements o_ref_pending; a tick and a GNT_REF completion in the same cycle leave it unchanged.
REQ-020 Decisions are taken only in IDLE; request inputs are ignored in grant states.
REQ-021 IDLE to grant state takes one cycle: request seen at edge N, grant high after edge N+1.
REQ-022 Refresh selection in IDLE: see REQ-031/REQ-032; otherwise a data grant follows.
REQ-023 Data selection: only one of i_wr_req/i_rd_req high grants it; both high grants the one not served last (round-robin pointer updated on every data grant).
REQ-024 Grant holds until i_done=1 sampled; next cycle state is IDLE and the grant is low; minimum one IDLE cycle between consecutive grants.
REQ-025 i_done while IDLE is ignored, with no effect on o_ref_pending.
REQ-026 i_init_done low forces IDLE, all grants 0, timer 0, o_ref_pending 0, regardless of the current state; o_ref_overflow is kept.
REQ-027 Counter widths: the timer is sized to hold REF_INTERVAL-1; no arithmetic wraps silently except the defined timer wrap.

Reset
REQ-028 i_rst_n=0 at a clock edge: state IDLE, all grants 0, o_busy 0, timer 0, o_ref_pending 0, o_ref_overflow 0, round-robin pointer = read (write wins first tie).
REQ-029 Reset mid-grant drops the grant at that edge with no completion accounting.
REQ-030 o_ref_overflow is cleared only by reset.

Configuration
REQ-031 With macro SDRAM_ARB_REFRESH_POSTPONE_EN defined: in IDLE, refresh is granted when o_ref_pending>0 and no data request is present, or when o_ref_pending=REF_PEND_MAX; otherwise data requests win.
REQ-032 Without SDRAM_ARB_REFRESH_POSTPONE_EN: in IDLE, refresh is granted whenever o_ref_pending>0, ahead of any data request.

Verification (REF_INTERVAL=16, REF_PEND_MAX=4)
REQ-033 Reset, init_done=1, wr_req high at cycle 3 -> o_wr_gnt high from cycle 4; i_done pulse at 10 -> o_wr_gnt low at 11, o_busy low at 11.
REQ-034 wr_req and rd_req held high, i_done 3 cycles after each grant -> grants alternate WR,RD,WR,RD; first grant is WR.
REQ-035 No requests, 16 idle cycles -> o_ref_pending=1, then o_ref_gnt next cycle; i_done -> o_ref_pending=0.
REQ-036 POSTPONE_EN, wr_req continuously high, 64 cycles -> pending reaches 4, next IDLE grants REF, not WR; without macro, REF is granted at the first IDLE after pending=1.
REQ-037 Tick and REF i_done same cycle with pending=2 -> pending stays 2; tick at pending=4 -> o_ref_overflow=1, pending stays 4.
REQ-038 i_init_done dropped during GNT_RD -> next cycle all grants 0, pending 0; i_rst_n low during GNT_WR -> grant 0 at that edge.
